// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   XLEN        : width of addresses and instruction words
//   HALT_INSN   : self-loop (beq x0,x0,0) that marks the end of a program
//   fetch_state_t : fetch FSM state encoding (2-bit)
//   fetch_entry_t : one queue entry, {pc, insn}
package instr_fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] HALT_INSN = 32'h0000_0063;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2,
        ST_ERROR  = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] insn;
    } fetch_entry_t;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_queue.sv
// Two-entry FIFO of fetched {pc, insn} pairs with registered head outputs.
//   clk, rst     : clock, synchronous active-high reset
//   enq          : push enq_entry (ignored while full)
//   enq_entry    : entry to push
//   ready        : consumer accepts the head this cycle (dequeue if head_valid)
//   flush        : discard all entries; overrides enq and dequeue
//   count        : number of stored entries (0..2), registered
//   head_valid   : head entry is valid
//   head         : head entry; holds its last value while the queue is empty
module instr_fetch_queue
    import instr_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         enq,
    input  fetch_entry_t enq_entry,
    input  logic         ready,
    input  logic         flush,
    output logic [1:0]   count,
    output logic         head_valid,
    output fetch_entry_t head
);

    fetch_entry_t second;
    logic         full;
    logic         do_enq;
    logic         do_deq;

    // Fullness comes from the registered count, so a same-cycle dequeue
    // never opens a slot for an enqueue.
    assign full   = (count == 2'd2);
    assign do_enq = enq && !full;
    assign do_deq = head_valid && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= 2'd0;
            head_valid <= 1'b0;
            head       <= '0;
            second     <= '0;
        end else if (flush) begin
            count      <= 2'd0;
            head_valid <= 1'b0;
        end else begin
            case (count)
                2'd0: begin
                    if (do_enq) begin
                        head       <= enq_entry;
                        count      <= 2'd1;
                        head_valid <= 1'b1;
                    end
                end
                2'd1: begin
                    if (do_enq && do_deq) begin
                        head <= enq_entry;
                    end else if (do_enq) begin
                        second <= enq_entry;
                        count  <= 2'd2;
                    end else if (do_deq) begin
                        count      <= 2'd0;
                        head_valid <= 1'b0;
                    end
                end
                2'd2: begin
                    if (do_deq) begin
                        head  <= second;
                        count <= 2'd1;
                    end
                end
                default: begin
                    count      <= 2'd0;
                    head_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, addresses the instruction ROM, and
// queues returned words for decode over a valid/ready handshake.
//   clk, rst        : clock, synchronous active-high reset
//   rom_addr        : ROM byte address (straight from the PC register)
//   rom_data        : ROM read data, combinational on rom_addr
//   redirect_valid  : load redirect_pc into the PC this cycle
//   redirect_pc     : redirect target, must be word aligned
//   instr_valid     : queue head valid
//   instr_ready     : decode accepts the head this cycle
//   instr           : head instruction word
//   instr_pc        : address the head word was fetched from
//   halted          : fetch stopped after a halt instruction
//   fetch_err       : misaligned redirect seen; cleared only by reset
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter bit          HALT_DETECT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        halted,
    output logic        fetch_err
);

    fetch_state_t  state;
    logic [31:0]   pc;
    logic [1:0]    q_count;
    logic          q_full;
    logic          redirect_take;
    logic          enq;
    logic          flush;
    fetch_entry_t  enq_entry;
    fetch_entry_t  head;

    assign rom_addr = pc;

    // Redirects are ignored once in ERROR; only reset leaves that state.
    assign redirect_take = redirect_valid && (state != ST_ERROR);
    assign q_full        = (q_count == 2'd2);
    assign enq           = (state == ST_FETCH) && !q_full && !redirect_take;
    assign flush         = redirect_take || (state == ST_ERROR);

    assign enq_entry.pc   = pc;
    assign enq_entry.insn = rom_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            state     <= ST_IDLE;
            halted    <= 1'b0;
            fetch_err <= 1'b0;
        end else if (redirect_take) begin
            if (is_word_aligned(redirect_pc)) begin
                pc     <= redirect_pc;
                state  <= ST_FETCH;
                halted <= 1'b0;
            end else begin
                state     <= ST_ERROR;
                halted    <= 1'b0;
                fetch_err <= 1'b1;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (enq) begin
                        // PC+4 wraps silently at the top of the address space.
                        pc <= pc + 32'd4;
                        if (HALT_DETECT && (rom_data == HALT_INSN)) begin
                            state  <= ST_HALTED;
                            halted <= 1'b1;
                        end
                    end
                end
                ST_HALTED: begin
                    state <= ST_HALTED;
                end
                default: begin
                    state <= ST_ERROR;
                end
            endcase
        end
    end

    instr_fetch_queue u_queue (
        .clk        (clk),
        .rst        (rst),
        .enq        (enq),
        .enq_entry  (enq_entry),
        .ready      (instr_ready),
        .flush      (flush),
        .count      (q_count),
        .head_valid (instr_valid),
        .head       (head)
    );

    assign instr    = head.insn;
    assign instr_pc = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance (RESET_PC=0, HALT_DETECT=1)
    logic        rst, redirect_valid, instr_ready, instr_valid, halted, fetch_err;
    logic [31:0] rom_addr, rom_data, redirect_pc, instr, instr_pc;

    // Wrap instance (RESET_PC=FFFF_FFFC, HALT_DETECT=0)
    logic        rst_w, redirect_valid_w, instr_ready_w, instr_valid_w, halted_w, fetch_err_w;
    logic [31:0] rom_addr_w, rom_data_w, redirect_pc_w, instr_w, instr_pc_w;

    int checks = 0;
    int errors = 0;

    // Program image (sumseq) plus a filler pattern that never equals the halt word.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h00: return 32'h00a54533;
            32'h04: return 32'h0052c2b3;
            32'h08: return 32'h00b50533;
            32'h0c: return 32'h00158593;
            32'h10: return 32'hfff60613;
            32'h14: return 32'hfe061ae3;
            32'h18: return 32'h00000013;
            32'h1c: return 32'h00000063;
            default: return (a * 32'h9e3779b1) | 32'h0000_0100;
        endcase
    endfunction

    assign rom_data   = rom_word(rom_addr);
    assign rom_data_w = rom_word(rom_addr_w);

    instr_fetch dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .halted(halted), .fetch_err(fetch_err)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .HALT_DETECT(1'b0)) dut_w (
        .clk(clk), .rst(rst_w), .rom_addr(rom_addr_w), .rom_data(rom_data_w),
        .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w),
        .instr_valid(instr_valid_w), .instr_ready(instr_ready_w), .instr(instr_w),
        .instr_pc(instr_pc_w), .halted(halted_w), .fetch_err(fetch_err_w)
    );

    // Transaction-level reference: the stream decode should see, as a queue.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] w;
    } ent_t;

    localparam int M_IDLE = 0, M_FETCH = 1, M_HALT = 2, M_ERR = 3;
    ent_t        mq[$];
    logic [31:0] m_pc;
    int          m_mode;

    task automatic model_step();
        if (rst) begin
            m_pc   = 32'h0;
            m_mode = M_IDLE;
            mq.delete();
        end else if (redirect_valid && m_mode != M_ERR) begin
            mq.delete();
            if (redirect_pc % 4 == 0) begin
                m_pc   = redirect_pc;
                m_mode = M_FETCH;
            end else begin
                m_mode = M_ERR;
            end
        end else if (m_mode == M_ERR) begin
            mq.delete();
        end else begin
            bit was_full;
            was_full = (mq.size() == 2);
            if (mq.size() > 0 && instr_ready) void'(mq.pop_front());
            if (m_mode == M_FETCH && !was_full) begin
                mq.push_back('{pc: m_pc, w: rom_word(m_pc)});
                if (rom_word(m_pc) == 32'h63) m_mode = M_HALT;
                m_pc = m_pc + 32'd4;
            end else if (m_mode == M_IDLE) begin
                m_mode = M_FETCH;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        chk("rom_addr", rom_addr, m_pc);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, mq.size() != 0});
        if (mq.size() != 0) begin
            chk("instr", instr, mq[0].w);
            chk("instr_pc", instr_pc, mq[0].pc);
        end
        chk("halted", {31'b0, halted}, {31'b0, m_mode == M_HALT});
        chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_mode == M_ERR});
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    initial begin
        rst = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        rst_w = 1'b1; instr_ready_w = 1'b0; redirect_valid_w = 1'b0; redirect_pc_w = 32'h0;
        m_pc = 32'h0; m_mode = M_IDLE;

        // 1. reset and first fetch latency
        cyc(); cyc();
        chk("rst_rom_addr", rom_addr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        chk("rst_err", {31'b0, fetch_err}, 32'h0);
        rst = 1'b0;
        cyc();
        chk("idle_addr", rom_addr, 32'h0);
        chk("idle_valid", {31'b0, instr_valid}, 32'h0);
        cyc();
        chk("first_valid", {31'b0, instr_valid}, 32'h1);
        chk("first_instr", instr, 32'h00a54533);
        chk("first_pc", instr_pc, 32'h0);

        // 2. streaming to halt
        instr_ready = 1'b1;
        cyc();
        chk("second_instr", instr, 32'h0052c2b3);
        chk("second_pc", instr_pc, 32'h4);
        repeat (10) cyc();
        chk("halt_flag", {31'b0, halted}, 32'h1);
        chk("halt_addr", rom_addr, 32'h20);
        chk("halt_drained", {31'b0, instr_valid}, 32'h0);

        // 4. redirect out of HALTED
        redirect_valid = 1'b1; redirect_pc = 32'h4;
        cyc();
        chk("redir_halted", {31'b0, halted}, 32'h0);
        chk("redir_flush", {31'b0, instr_valid}, 32'h0);
        redirect_valid = 1'b0;
        cyc();
        chk("redir_instr", instr, 32'h0052c2b3);
        chk("redir_pc", instr_pc, 32'h4);

        // 3. back-pressure from reset
        rst = 1'b1; instr_ready = 1'b0;
        cyc();
        rst = 1'b0;
        repeat (6) cyc();
        chk("bp_addr", rom_addr, 32'h8);
        chk("bp_head", instr_pc, 32'h0);
        instr_ready = 1'b1;
        cyc();
        chk("bp_head2", instr_pc, 32'h4);
        cyc();
        chk("bp_head3", instr_pc, 32'h8);

        // 5. misaligned redirect while streaming
        redirect_valid = 1'b1; redirect_pc = 32'h6;
        cyc();
        chk("err_flag", {31'b0, fetch_err}, 32'h1);
        chk("err_valid", {31'b0, instr_valid}, 32'h0);
        redirect_pc = 32'h4;
        cyc();
        chk("err_sticky", {31'b0, fetch_err}, 32'h1);
        redirect_valid = 1'b0;
        repeat (3) cyc();
        chk("err_valid_hold", {31'b0, instr_valid}, 32'h0);
        rst = 1'b1;
        cyc();
        chk("err_cleared", {31'b0, fetch_err}, 32'h0);
        chk("err_restart", rom_addr, 32'h0);
        rst = 1'b0;

        // Randomized traffic against the reference
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 199);
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = (r < 12);
            redirect_pc    = (r < 10) ? {26'b0, 4'($urandom_range(0, 15)), 2'b00}
                                      : {28'b0, 2'($urandom_range(0, 3)), 2'b10};
            rst            = (r == 199);
            cyc();
        end
        rst = 1'b1; redirect_valid = 1'b0;

        // 6. wrap-around PC and redirect with simultaneous dequeue
        cyc();
        chk("w_rst_addr", rom_addr_w, 32'hFFFF_FFFC);
        chk("w_rst_valid", {31'b0, instr_valid_w}, 32'h0);
        rst_w = 1'b0;
        cyc(); cyc();
        chk("w_first_pc", instr_pc_w, 32'hFFFF_FFFC);
        chk("w_first_instr", instr_w, rom_word(32'hFFFF_FFFC));
        chk("w_wrap_addr", rom_addr_w, 32'h0);
        instr_ready_w = 1'b1;
        cyc();
        chk("w_wrap_pc", instr_pc_w, 32'h0);
        chk("w_wrap_instr", instr_w, 32'h00a54533);
        redirect_valid_w = 1'b1; redirect_pc_w = 32'h10;
        cyc();
        chk("w_redir_flush", {31'b0, instr_valid_w}, 32'h0);
        chk("w_redir_addr", rom_addr_w, 32'h10);
        redirect_valid_w = 1'b0;
        cyc();
        chk("w_redir_head", instr_pc_w, 32'h10);
        repeat (4) cyc();
        chk("w_nohalt", {31'b0, halted_w}, 32'h0);
        chk("w_nohalt_addr", rom_addr_w, 32'h24);
        chk("w_nohalt_head", instr_pc_w, 32'h20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
